uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start, 5..9 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_CTS_EN to add the cts_n clear-to-send input that gates the start of each frame.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
`ifdef UART_TX_CTS_EN
   input  logic                        cts_n,
`endif
   input  logic [DIV_WIDTH-1:0]        div,
   input  logic [1:0]                  cfg_parity,
   input  logic                        cfg_stop,
   input  logic [DATA_WIDTH-1:0]       txd,
   input  logic                        txv,
   output logic                        txr,
   output logic                        tx,
   output logic                        active,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_level;
   logic [AW:0]           w_level_next;
   logic                  r_txr;
   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_head;

   state_t                r_state;
   state_t                w_state_next;
   logic [DIV_WIDTH-1:0]  r_cnt;
   logic [DIV_WIDTH-1:0]  w_cnt_next;
   logic [DIV_WIDTH-1:0]  r_div;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic [IW-1:0]         r_idx;
   logic [IW-1:0]         w_idx_next;
   logic                  r_stop2;
   logic                  w_stop2_next;
   logic                  r_par_en;
   logic                  r_par_bit;
   logic                  r_two_stop;
   logic                  r_tx;
   logic                  w_tx_next;
   logic                  w_bit_end;
   logic                  w_can_start;
   logic                  w_cts_ok;

`ifdef UART_TX_CTS_EN
   logic r_cts_meta;
   logic r_cts_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cts_meta <= 1'b1;
         r_cts_sync <= 1'b1;
      end else begin
         r_cts_meta <= cts_n;
         r_cts_sync <= r_cts_meta;
      end
   end

   assign w_cts_ok = ~r_cts_sync;
`else
   assign w_cts_ok = 1'b1;
`endif

   assign w_push      = txv && r_txr;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_bit_end   = (r_cnt == '0);
   assign w_can_start = (r_level != '0) && w_cts_ok;

   always_comb begin
      w_level_next = r_level;
      if (w_push && !w_pop) begin
         w_level_next = r_level + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
         w_level_next = r_level - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= txd;
      end
   end

   // txr is registered from the next level so it stays low throughout reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_txr    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= w_level_next;
         r_txr   <= (w_level_next < (AW+1)'(FIFO_DEPTH));
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = w_bit_end ? r_cnt : r_cnt - DIV_WIDTH'(1);
      w_shift_next = r_shift;
      w_idx_next   = r_idx;
      w_stop2_next = r_stop2;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_can_start) begin
               w_pop        = 1'b1;
               w_state_next = START;
               w_cnt_next   = div;
               w_shift_next = w_head;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_next = DATA;
               w_cnt_next   = r_div;
               w_idx_next   = '0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_cnt_next = r_div;
               if (r_idx == IW'(DATA_WIDTH-1)) begin
                  w_state_next = r_par_en ? PARITY : STOP;
                  w_stop2_next = 1'b0;
               end else begin
                  w_idx_next   = r_idx + IW'(1);
                  w_shift_next = r_shift >> 1;
               end
            end
         end
         PARITY: begin
            if (w_bit_end) begin
               w_state_next = STOP;
               w_stop2_next = 1'b0;
               w_cnt_next   = r_div;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               if (r_two_stop && !r_stop2) begin
                  w_stop2_next = 1'b1;
                  w_cnt_next   = r_div;
               end else if (w_can_start) begin
                  w_pop        = 1'b1;
                  w_state_next = START;
                  w_cnt_next   = div;
                  w_shift_next = w_head;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      case (w_state_next)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = w_shift_next[0];
         PARITY:  w_tx_next = r_par_bit;
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_idx   <= '0;
         r_stop2 <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_shift <= w_shift_next;
         r_idx   <= w_idx_next;
         r_stop2 <= w_stop2_next;
         r_tx    <= w_tx_next;
      end
   end

   // Frame settings are captured at the pop so mid-frame input changes wait for the next frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div      <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_two_stop <= 1'b0;
      end else if (w_pop) begin
         r_div      <= div;
         r_par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
         r_par_bit  <= (^w_head) ^ cfg_parity[1];
         r_two_stop <= cfg_stop;
      end
   end

   assign tx         = r_tx;
   assign active     = (r_state != IDLE);
   assign txr        = r_txr;
   assign fifo_level = r_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table plus corner-case sequences,
// with a line monitor that checks every cycle of each frame against a scoreboard.
module tb_uart_tx_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] div = 16'd3;
   logic [1:0]  cfg_parity = 2'b00;
   logic        cfg_stop = 1'b0;
   logic [7:0]  txd = 8'h00;
   logic        txv = 1'b0;
   logic        txr;
   logic        tx;
   logic        active;
   logic [4:0]  fifo_level;
`ifdef UART_TX_CTS_EN
   logic        cts_n = 1'b0;
`endif

   uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef UART_TX_CTS_EN
      .cts_n      (cts_n),
`endif
      .div        (div),
      .cfg_parity (cfg_parity),
      .cfg_stop   (cfg_stop),
      .txd        (txd),
      .txv        (txv),
      .txr        (txr),
      .tx         (tx),
      .active     (active),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] divVal;
      logic [1:0]  parity;
      logic        stop;
      int          expLen;
      logic [11:0] expBits;
   } vector_t;

   vector_t     vectors [6];
   int          testsRun = 0;
   int          testsFailed = 0;
   logic [7:0]  sbQ [$];
   int          monLevels [$];
   bit          monBusy = 1'b0;
   int          monFrames = 0;
   logic [11:0] monLastBits = '0;
   int          idleActiveErr = 0;
   int          curRun = 0;
   int          lastRun = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input bit expectAccept);
      txd = data;
      txv = 1'b1;
      @(posedge clk);
      #1;
      txv = 1'b0;
      if (expectAccept) sbQ.push_back(data);
   endtask

   task automatic stepNeg(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic waitFrameEnd(input int bound);
      int n = 0;
      while (active !== 1'b0 && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("idleTimeout", {31'd0, active}, 0);
   endtask

   // Line monitor: rebuilds each expected frame from the scoreboard word and the settings at its start
   initial begin
      logic [7:0]  word;
      logic [11:0] expBits;
      logic [11:0] capBits;
      int          nBits;
      int          bitIdx;
      int          cyc;
      int          divL;
      int          errCnt;
      forever begin
         @(negedge clk);
         if (!rst) begin
            monBusy = 1'b0;
         end else begin
            if (!monBusy) begin
               if (tx === 1'b0) begin
                  if (sbQ.size() == 0) begin
                     testsRun++;
                     testsFailed++;
                     $display("[TB] FAIL unexpectedFrame: start bit with empty scoreboard, expected idle line");
                     word = 8'h00;
                  end else begin
                     word = sbQ.pop_front();
                  end
                  divL    = int'(div);
                  expBits = '1;
                  expBits[0] = 1'b0;
                  for (int i = 0; i < 8; i++) expBits[1+i] = word[i];
                  nBits = 10 + (cfg_stop ? 1 : 0);
                  if (cfg_parity == 2'b01 || cfg_parity == 2'b10) begin
                     expBits[9] = (^word) ^ (cfg_parity == 2'b10);
                     nBits++;
                  end
                  capBits = '0;
                  bitIdx  = 0;
                  cyc     = 0;
                  errCnt  = 0;
                  monBusy = 1'b1;
               end else if (active !== 1'b0) begin
                  idleActiveErr++;
               end
            end
            if (monBusy) begin
               if (cyc == 0) capBits[bitIdx] = tx;
               if (cyc == 0 && bitIdx == 5) monLevels.push_back(int'(fifo_level));
               if (tx !== expBits[bitIdx] || active !== 1'b1) errCnt++;
               cyc++;
               if (cyc == divL + 1) begin
                  checkOutput($sformatf("lineBit%0d", bitIdx), errCnt, 0);
                  errCnt = 0;
                  cyc    = 0;
                  bitIdx++;
                  if (bitIdx == nBits) begin
                     monBusy     = 1'b0;
                     monFrames++;
                     monLastBits = capBits;
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (active === 1'b1) begin
            curRun++;
         end else begin
            if (curRun != 0) lastRun = curRun;
            curRun = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int framesBefore;
      vectors[0] = '{8'hA5, 16'd3, 2'b00, 1'b0, 40, 12'h34A};
      vectors[1] = '{8'h07, 16'd3, 2'b01, 1'b1, 48, 12'hE0E};
      vectors[2] = '{8'h07, 16'd3, 2'b10, 1'b0, 44, 12'h40E};
      vectors[3] = '{8'h3C, 16'd1, 2'b11, 1'b0, 20, 12'h278};
      vectors[4] = '{8'h00, 16'd2, 2'b10, 1'b0, 33, 12'h600};
      vectors[5] = '{8'hFF, 16'd2, 2'b01, 1'b1, 36, 12'hDFE};

      stepNeg(3);
      checkOutput("rstTx", {31'd0, tx}, 1);
      checkOutput("rstActive", {31'd0, active}, 0);
      checkOutput("rstTxr", {31'd0, txr}, 0);
      checkOutput("rstLevel", {27'd0, fifo_level}, 0);
      rst = 1'b1;
      checkOutput("txrBeforeEdge", {31'd0, txr}, 0);
      @(posedge clk);
      #1;
      checkOutput("txrAfterRelease", {31'd0, txr}, 1);
      stepNeg(3);

      for (int v = 0; v < 6; v++) begin
         div        = vectors[v].divVal;
         cfg_parity = vectors[v].parity;
         cfg_stop   = vectors[v].stop;
         applyStimulus(vectors[v].data, 1'b1);
         checkOutput("preStart", {31'd0, tx}, 1);
         @(posedge clk);
         #1;
         checkOutput("startBit", {31'd0, tx}, 0);
         waitFrameEnd(500);
         checkOutput("frameLen", lastRun, vectors[v].expLen);
         checkOutput("frameBits", {20'd0, monLastBits}, {20'd0, vectors[v].expBits});
         stepNeg(2);
      end

      // Back-to-back frames keep active high and drain the level 2,1,0
      div = 16'd3;
      cfg_parity = 2'b00;
      cfg_stop = 1'b0;
      monLevels.delete();
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      applyStimulus(8'h33, 1'b1);
      waitFrameEnd(1000);
      checkOutput("b2bRun", lastRun, 120);
      checkOutput("b2bLevelCount", monLevels.size(), 3);
      for (int i = 0; i < 3; i++) begin
         checkOutput("b2bLevel", (i < monLevels.size()) ? monLevels[i] : -1, 2 - i);
      end
      stepNeg(2);

      // Divisor change mid-frame only affects the following frame
      applyStimulus(8'h96, 1'b1);
      applyStimulus(8'h69, 1'b1);
      stepNeg(10);
      div = 16'd7;
      waitFrameEnd(1000);
      checkOutput("divChangeRun", lastRun, 120);
      checkOutput("divChangeBits", {20'd0, monLastBits}, 32'h2D2);
      div = 16'd3;
      stepNeg(2);

      // Reset in data bit 3 aborts the frame and flushes the queued word
      applyStimulus(8'hF0, 1'b1);
      applyStimulus(8'hAB, 1'b1);
      repeat (17) begin
         @(posedge clk);
         #1;
      end
      #2;
      checkOutput("txBeforeReset", {31'd0, tx}, 0);
      checkOutput("levelBeforeReset", {27'd0, fifo_level}, 1);
      rst = 1'b0;
      #1;
      checkOutput("abortTx", {31'd0, tx}, 1);
      checkOutput("abortActive", {31'd0, active}, 0);
      checkOutput("abortLevel", {27'd0, fifo_level}, 0);
      checkOutput("abortTxr", {31'd0, txr}, 0);
      sbQ.delete();
      stepNeg(2);
      rst = 1'b1;
      stepNeg(3);
      applyStimulus(8'h3C, 1'b1);
      checkOutput("postRstPreStart", {31'd0, tx}, 1);
      @(posedge clk);
      #1;
      checkOutput("postRstStart", {31'd0, tx}, 0);
      waitFrameEnd(500);
      checkOutput("postRstLen", lastRun, 40);
      checkOutput("postRstBits", {20'd0, monLastBits}, 32'h278);
      stepNeg(2);

      // Fill the FIFO to depth, drop one extra word, then drain it all
      div = 16'd1;
      framesBefore = monFrames;
`ifdef UART_TX_CTS_EN
      cts_n = 1'b1;
      stepNeg(4);
      for (int i = 1; i <= 16; i++) applyStimulus(8'(i), 1'b1);
      checkOutput("fullLevel", {27'd0, fifo_level}, 16);
      checkOutput("fullTxr", {31'd0, txr}, 0);
      applyStimulus(8'hEE, 1'b0);
      checkOutput("ctsBlocked", {31'd0, active}, 0);
      cts_n = 1'b0;
      for (int n = 0; n < 20 && active !== 1'b1; n++) stepNeg(1);
      waitFrameEnd(2000);
      checkOutput("fillFrames", monFrames - framesBefore, 16);
      checkOutput("fillRun", lastRun, 320);
`else
      applyStimulus(8'h00, 1'b1);
      for (int i = 1; i <= 16; i++) applyStimulus(8'(i), 1'b1);
      checkOutput("fullLevel", {27'd0, fifo_level}, 16);
      checkOutput("fullTxr", {31'd0, txr}, 0);
      applyStimulus(8'hEE, 1'b0);
      checkOutput("fullLevelAfterDrop", {27'd0, fifo_level}, 16);
      waitFrameEnd(2000);
      checkOutput("fillFrames", monFrames - framesBefore, 17);
      checkOutput("fillRun", lastRun, 340);
`endif
      stepNeg(3);

      checkOutput("idleActive", idleActiveErr, 0);
      checkOutput("scoreboardEmpty", sbQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
